// File: rtl/pre_emph_pkg.sv
// Shared MEL front-end package: Q1.15 constants and a saturate-to-width helper.
// The helpers work on a wide signed value so later stages can reuse them at any width up to SAT_MAX_W.
package pre_emph_pkg;

  localparam int Q_FRAC        = 15;
  localparam int ROUND_HALF    = 1 << 14;
  localparam int ALPHA_DEFAULT = 31785;
  localparam int SAT_MAX_W     = 48;

  function automatic logic signed [SAT_MAX_W-1:0] sat_hi(input int w);
    return (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
  endfunction

  function automatic logic signed [SAT_MAX_W-1:0] sat_lo(input int w);
    return -sat_hi(w) - SAT_MAX_W'(1);
  endfunction

  function automatic logic needs_sat(input logic signed [SAT_MAX_W-1:0] v, input int w);
    return (v > sat_hi(w)) || (v < sat_lo(w));
  endfunction

  function automatic logic signed [SAT_MAX_W-1:0] sat_to_width(
      input logic signed [SAT_MAX_W-1:0] v, input int w);
    if (v > sat_hi(w)) return sat_hi(w);
    if (v < sat_lo(w)) return sat_lo(w);
    return v;
  endfunction

endpackage

// File: rtl/pre_emph_if.sv
// Sample-in handshake plus the window stage's write port, seen from both sides.
interface pre_emph_if #(
    parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    data_full;
  logic                    den;
  logic signed [WIDTH-1:0] din_re;
  logic signed [WIDTH-1:0] din_im;

  modport master (output in_valid, in_data, data_full, input in_ready, den, din_re, din_im);
  modport slave  (input in_valid, in_data, data_full, output in_ready, den, din_re, din_im);
endinterface

// File: rtl/pre_emph_skid_fifo2.sv
// Generic two-entry FIFO; push while full and pop while empty are ignored.
module skid_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < 2; i++) mem_d[i] = mem_q[i];
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: rtl/pre_emph.sv
// Streaming pre-emphasis y[n] = x[n] - ALPHA*x[n-1] (Q1.15, round half up, saturate),
// emitted as complex samples with zero imaginary part onto the window stage's write port.
module pre_emph
  import pre_emph_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ALPHA     = ALPHA_DEFAULT,
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pre_emph_if.slave            bus,
    input  logic                 frm_clear,
    output logic [SAT_CNT_W-1:0] sat_cnt
);
  localparam int PW = WIDTH + 16;
  localparam int AW = WIDTH + 17;
  localparam logic signed [16:0] ALPHA_S = 17'(ALPHA);

  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [1:0]       fifo_count;

  logic signed [WIDTH-1:0] h_q, h_d;
  logic                    p1_valid_q, p1_valid_d;
  logic signed [WIDTH-1:0] p1_x_q, p1_x_d;
  logic signed [PW-1:0]    p1_prod_q, p1_prod_d;
  logic                    p2_valid_q, p2_valid_d;
  logic signed [WIDTH-1:0] p2_y_q, p2_y_d;
  logic [SAT_CNT_W-1:0]    sat_cnt_q, sat_cnt_d;

  logic                        den_c, p1_load, p2_load, clip;
  logic signed [WIDTH-1:0]     h_sel;
  logic signed [PW-1:0]        prod;
  logic signed [AW-1:0]        acc;
  logic signed [SAT_MAX_W-1:0] y_wide;

  assign fifo_push = bus.in_valid && !fifo_full;
  assign fifo_pop  = p1_load;

  skid_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (bus.in_data),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
  );

  always_comb begin
    den_c   = p2_valid_q && !bus.data_full;
    p2_load = p1_valid_q && (!p2_valid_q || den_c);
    p1_load = !fifo_empty && (!p1_valid_q || p2_load);
    // A restart pulse coinciding with a load must already see zero history.
    h_sel   = frm_clear ? '0 : h_q;
    prod    = PW'(ALPHA_S) * PW'(h_sel);
    acc     = (AW'(p1_x_q) <<< Q_FRAC) - AW'(p1_prod_q) + AW'(ROUND_HALF);
    y_wide  = SAT_MAX_W'(acc >>> Q_FRAC);
    clip    = needs_sat(y_wide, WIDTH);

    h_d        = h_q;
    p1_valid_d = p1_valid_q;
    p1_x_d     = p1_x_q;
    p1_prod_d  = p1_prod_q;
    p2_valid_d = p2_valid_q;
    p2_y_d     = p2_y_q;
    sat_cnt_d  = sat_cnt_q;

    if (p1_load) begin
      p1_valid_d = 1'b1;
      p1_x_d     = $signed(fifo_head);
      p1_prod_d  = prod;
      h_d        = $signed(fifo_head);
    end else begin
      if (p2_load) p1_valid_d = 1'b0;
      if (frm_clear) h_d = '0;
    end

    if (p2_load) begin
      p2_valid_d = 1'b1;
      p2_y_d     = WIDTH'(sat_to_width(y_wide, WIDTH));
      if (clip && (sat_cnt_q != {SAT_CNT_W{1'b1}})) sat_cnt_d = sat_cnt_q + 1'b1;
    end else if (den_c) begin
      p2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q        <= '0;
      p1_valid_q <= 1'b0;
      p1_x_q     <= '0;
      p1_prod_q  <= '0;
      p2_valid_q <= 1'b0;
      p2_y_q     <= '0;
      sat_cnt_q  <= '0;
    end else begin
      h_q        <= h_d;
      p1_valid_q <= p1_valid_d;
      p1_x_q     <= p1_x_d;
      p1_prod_q  <= p1_prod_d;
      p2_valid_q <= p2_valid_d;
      p2_y_q     <= p2_y_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign bus.in_ready = (fifo_count != 2'd2);
  assign bus.den      = den_c;
  assign bus.din_re   = p2_y_q;
  assign bus.din_im   = '0;
  assign sat_cnt      = sat_cnt_q;
endmodule

// File: tb/tb_pre_emph.sv
// Bench for pre_emph: directed vector table, back-pressure and reset sequences,
// and randomized traffic scored against an arithmetic model of the filter.
module tb_pre_emph;
  localparam int W = 16;
  localparam int ALPHA_A = 31785;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frm_clear_a = 1'b0;
  logic frm_clear_b = 1'b0;
  logic [15:0] sat_cnt_a, sat_cnt_b;

  pre_emph_if #(.WIDTH(W)) bus_a ();
  pre_emph_if #(.WIDTH(W)) bus_b ();

  pre_emph #(.WIDTH(W), .ALPHA(ALPHA_A), .SAT_CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .frm_clear(frm_clear_a), .sat_cnt(sat_cnt_a));
  pre_emph #(.WIDTH(W), .ALPHA(0), .SAT_CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .frm_clear(frm_clear_b), .sat_cnt(sat_cnt_b));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference: y = floor((x*2^15 - alpha*prev + 2^14) / 2^15), clamped to 16-bit signed.
  function automatic longint model_raw(input longint x, input longint prev, input longint alpha);
    longint num;
    num = x * 32768 - alpha * prev + 16384;
    return num >>> 15;
  endfunction

  longint sb_q[$];
  longint sb_prev = 0;
  int     sb_sat = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q.delete();
      sb_prev = 0;
      sb_sat  = 0;
    end else begin
      if (bus_a.den) begin
        if (sb_q.size() == 0) chk(1'b0, "sb_unexpected_den", longint'(bus_a.din_re), 0);
        else begin
          longint e;
          e = sb_q.pop_front();
          chk(longint'(bus_a.din_re) == e, "sb_din_re", longint'(bus_a.din_re), e);
        end
      end
      if (bus_a.in_valid && bus_a.in_ready) begin
        longint r;
        r = model_raw(longint'(bus_a.in_data), sb_prev, ALPHA_A);
        if (r > 32767 || r < -32768) begin
          r = (r > 32767) ? 32767 : -32768;
          if (sb_sat < 65535) sb_sat++;
        end
        sb_q.push_back(r);
        sb_prev = longint'(bus_a.in_data);
      end
    end
  end

  typedef struct {
    int x;
    bit clr_before;
    bit clr_at_load;
    int exp_y;
    int exp_sat;
  } vec_t;
  vec_t vecs[10];

  task automatic send_one(input int idx);
    vec_t v;
    bit   seen;
    v = vecs[idx];
    if (v.clr_before) begin
      frm_clear_a = 1'b1;
      @(posedge clk); #1;
      frm_clear_a = 1'b0;
      sb_prev = 0;
    end
    if (v.clr_at_load) sb_prev = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 16'(v.x);
    @(negedge clk);
    chk(bus_a.in_ready == 1'b1, "vec_in_ready", longint'(bus_a.in_ready), 1);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    if (v.clr_at_load) frm_clear_a = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (bus_a.den) begin
        seen = 1'b1;
        $display("vec %0d: in=%0d out=%0d sat=%0d lat=%0d", idx, v.x, bus_a.din_re, sat_cnt_a, c);
        chk(c == 3, "vec_latency", c, 3);
        chk(longint'(bus_a.din_re) == v.exp_y, "vec_din_re", longint'(bus_a.din_re), v.exp_y);
        chk(longint'(bus_a.din_im) == 0, "vec_din_im", longint'(bus_a.din_im), 0);
        chk(longint'(sat_cnt_a) == v.exp_sat, "vec_sat_cnt", longint'(sat_cnt_a), v.exp_sat);
      end
      @(posedge clk); #1;
      frm_clear_a = 1'b0;
    end
    if (!seen) chk(1'b0, "vec_den_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint got[$];
    int     acc_n, first_edge, max_out, nxt;
    bit     rdy, fire, have_stall, release_chk;
    longint stall_val;

    vecs[0] = '{1000,   1, 0, 1000,   0};
    vecs[1] = '{1000,   0, 0, 30,     0};
    vecs[2] = '{0,      0, 0, -970,   0};
    vecs[3] = '{32767,  1, 0, 32767,  0};
    vecs[4] = '{-32768, 0, 0, -32768, 1};
    vecs[5] = '{-32768, 1, 0, -32768, 1};
    vecs[6] = '{32767,  0, 0, 32767,  2};
    vecs[7] = '{1000,   1, 0, 1000,   2};
    vecs[8] = '{1000,   0, 1, 1000,   2};
    vecs[9] = '{500,    0, 0, 500,    0};

    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.data_full = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.data_full = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(bus_a.in_ready == 1'b1, "rst_in_ready", longint'(bus_a.in_ready), 1);
    chk(bus_a.den == 1'b0, "rst_den", longint'(bus_a.den), 0);
    chk(bus_a.din_re == 0, "rst_din_re", longint'(bus_a.din_re), 0);
    chk(bus_a.din_im == 0, "rst_din_im", longint'(bus_a.din_im), 0);
    chk(sat_cnt_a == 0, "rst_sat_cnt", longint'(sat_cnt_a), 0);
    chk(bus_b.in_ready == 1'b1, "rst_b_in_ready", longint'(bus_b.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i <= 8; i++) send_one(i);

    // Back-pressure on the ALPHA=0 instance: 1..10 with an 8-cycle stall.
    acc_n = 0; first_edge = -1; max_out = 0; nxt = 1;
    have_stall = 1'b0; release_chk = 1'b0; stall_val = 0;
    bus_b.in_valid = 1'b1; bus_b.in_data = 16'(1);
    for (int k = 0; k < 80 && got.size() < 10; k++) begin
      int outstanding;
      @(negedge clk);
      rdy  = bus_b.in_ready;
      fire = bus_b.in_valid && rdy;
      outstanding = acc_n - got.size();
      if (outstanding > max_out) max_out = outstanding;
      chk(rdy == (outstanding != 4), "bp_in_ready", longint'(rdy), longint'(outstanding != 4));
      if (bus_b.data_full) begin
        chk(!bus_b.den, "bp_den_while_full", longint'(bus_b.den), 0);
        if (!have_stall) begin
          stall_val  = longint'(bus_b.din_re);
          have_stall = 1'b1;
        end else
          chk(longint'(bus_b.din_re) == stall_val, "bp_stable", longint'(bus_b.din_re), stall_val);
      end
      if (release_chk) begin
        chk(bus_b.den == 1'b1, "bp_release_den", longint'(bus_b.den), 1);
        release_chk = 1'b0;
      end
      if (bus_b.den) begin
        got.push_back(longint'(bus_b.din_re));
        $display("bp: out=%0d", bus_b.din_re);
      end
      @(posedge clk); #1;
      if (fire) begin
        acc_n++;
        if (first_edge < 0) first_edge = k;
        if (nxt < 10) begin
          nxt++;
          bus_b.in_data = 16'(nxt);
        end else bus_b.in_valid = 1'b0;
      end
      if (first_edge >= 0 && k == first_edge + 2) bus_b.data_full = 1'b1;
      if (first_edge >= 0 && k == first_edge + 10) begin
        bus_b.data_full = 1'b0;
        release_chk = 1'b1;
      end
    end
    bus_b.in_valid = 1'b0;
    bus_b.data_full = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk(!bus_b.den, "bp_extra_den", longint'(bus_b.den), 0);
    end
    @(posedge clk); #1;
    chk(max_out == 4, "bp_max_outstanding", max_out, 4);
    chk(got.size() == 10, "bp_count", got.size(), 10);
    for (int i = 0; i < got.size(); i++) chk(got[i] == i + 1, "bp_order", got[i], i + 1);
    chk(sat_cnt_b == 0, "bp_sat_cnt", longint'(sat_cnt_b), 0);

    // Randomized traffic on the ALPHA=31785 instance.
    for (int c = 0; c < 600; c++) begin
      int r;
      bus_a.in_valid = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 7);
      if (r == 0) bus_a.in_data = 16'sh7fff;
      else if (r == 1) bus_a.in_data = 16'sh8000;
      else bus_a.in_data = 16'($urandom);
      bus_a.data_full = (c >= 200 && c < 230) ? 1'b1 : ($urandom_range(0, 9) < 3);
      @(posedge clk); #1;
    end
    bus_a.in_valid = 1'b0;
    bus_a.data_full = 1'b0;
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk(sb_q.size() == 0, "rand_drain", sb_q.size(), 0);
    chk(longint'(sat_cnt_a) == sb_sat, "rand_sat_cnt", longint'(sat_cnt_a), sb_sat);

    // Reset while P2 and the FIFO are full, releasing data_full just before.
    bus_a.data_full = 1'b1;
    bus_a.in_valid  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus_a.in_data = 16'(100 + c);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk(bus_a.in_ready == 1'b0, "fill_in_ready", longint'(bus_a.in_ready), 0);
    @(posedge clk); #1;
    bus_a.in_valid  = 1'b0;
    bus_a.data_full = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk(bus_a.den == 1'b0, "midrst_den", longint'(bus_a.den), 0);
    chk(bus_a.in_ready == 1'b1, "midrst_in_ready", longint'(bus_a.in_ready), 1);
    chk(sat_cnt_a == 0, "midrst_sat_cnt", longint'(sat_cnt_a), 0);
    chk(bus_a.din_re == 0, "midrst_din_re", longint'(bus_a.din_re), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_one(9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pre_emph.md
# pre_emph

Streaming pre-emphasis stage that sits directly upstream of the Hann-window/overlap buffer stage in the MEL front end. It accepts real audio samples over a valid/ready handshake and computes y[n] = x[n] − α·x[n−1] in fixed point with rounding and saturation. It presents each result as a complex sample with zero imaginary part on the window stage's write port (`den`, `din_re`, `din_im`). It honours that stage's `data_full` back-pressure without losing or reordering samples.

## Interface
- `WIDTH`, 16: sample width; signed two's complement.
- `ALPHA`, 31785: pre-emphasis coefficient, unsigned Q1.15 (0.97). Legal range is 0..32767. 0 gives pass-through.
- `SAT_CNT_W`, 16: width of the saturation event counter.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  stage can accept a sample.
- `in_data`  in  WIDTH  signed input sample.
- `frm_clear`  in  1  forces the history sample to 0 for the next popped sample (stream restart).
- `data_full`  in  1  back-pressure from the window stage.
- `den`  out  1  write strobe to the window stage.
- `din_re`  out  WIDTH  pre-emphasised sample.
- `din_im`  out  WIDTH  constant 0.
- `sat_cnt`  out  SAT_CNT_W  number of saturated outputs; sticks at all-ones.

## Operation
- **Skid FIFO (depth 2).**
  - A sample is accepted on an edge where `in_valid && in_ready`.
  - `in_ready = (fifo_cnt != 2)`, decoded from the registered count only.
  - Simultaneous push and pop leaves the count unchanged.
- **P1 (multiply).**
  - Loads the FIFO head when the FIFO is non-empty and P1 is empty or advancing.
  - Registers `x` and `prod = ALPHA * h`, a signed product of width WIDTH+16. `h` is the history register.
  - On the load, `h <= x`.
  - If `frm_clear` is high in the load cycle, the product uses `h = 0`.
  - If `frm_clear` is high with no load, `h` is cleared.
- **P2 (output register).**
  - Loads from P1 when P1 is valid and P2 is empty or emitting this cycle.
  - Computes `acc = (x <<< 15) − prod + 2^14`, then `y = acc >>> 15` (round half up).
  - Saturates `y` to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Each clip increments `sat_cnt` unless it is already all-ones.
- **Emission.**
  - `den = p2_valid && !data_full`, combinational.
  - P2 clears on `den` unless refilled the same edge.
  - `din_re` holds the P2 value and is stable while stalled.
- **Ordering.** No sample is dropped, duplicated or reordered under any `data_full` pattern.
- **Reset.** Mid-operation reset discards the FIFO, P1, P2 and `h`.

## Timing
- **Reset values:**
  - `in_ready` = 1
  - `den` = 0
  - `din_re` = 0
  - `din_im` = 0
  - `sat_cnt` = 0
  - `h` = 0
  - all valid bits = 0
- **Latency.** A sample accepted at edge t reaches P1 at t+1 and P2 at t+2. `den` is high in the cycle after t+2 if `data_full` is low.
- **Throughput.** One sample per cycle with `data_full` low.
- **Stall capacity.** With `data_full` held high, at most 4 samples are outstanding (FIFO 2, P1, P2). `in_ready` falls after the 4th acceptance.
- **Stall release.** After `data_full` deasserts, `den` rises the same cycle. `in_ready` returns within 2 cycles.
- **`frm_clear`.** Single-cycle pulse, takes effect on the same edge.

## Structure
- The shared MEL package holds:
  - the Q1.15 constants: `Q_FRAC` = 15, `ROUND_HALF` = 2^14, default `ALPHA`;
  - a saturate-to-WIDTH function, reused by later stages.
- One sub-module, `skid_fifo2`: a generic 2-entry FIFO with `push`, `pop`, `full`, `empty` and `count`.
- P1/P2 control stays in `pre_emph`.

## Test plan
- **Basic response.** `ALPHA`=31785; stream 1000, 1000, 0 with `data_full`=0. Expect `din_re` = 1000, 30, −970. `den` is high 3 cycles after each acceptance. `sat_cnt` stays 0.
- **Negative saturation.** Stream 32767, −32768. Expect 32767, then −32768 (clipped). `sat_cnt` = 1.
- **Positive saturation.** Stream −32768, 32767. Expect −32768, then 32767 (clipped). `sat_cnt` = 2 cumulative after the previous test.
- **Back-pressure.**
  - Stream 10 samples 1..10 with `ALPHA`=0 and `in_valid` held high.
  - Hold `data_full`=1 for 8 cycles starting 2 cycles after the first acceptance.
  - Expect: `in_ready` drops after 4 outstanding samples; outputs are exactly 1..10 in order, one `den` per sample; `din_re` is stable while stalled.
- **`frm_clear`.** Stream 1000, then 1000 with `frm_clear` pulsed on the second sample's P1-load edge. Expect 1000, 1000.
- **Reset mid-stream.** Assert `rst_n`=0 while P2 and the FIFO are full. Expect `den`=0, `in_ready`=1, `sat_cnt`=0 immediately. The next sample 500 outputs 500.
